// File: rtl/uart_tx_buffered_if.sv
// Byte producer -> UART TX buffer handshake; byte moves on posedge when in_valid && in_ready.
interface uart_tx_buffered_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART TX: byte FIFO feeding a serialiser, first start bit one clk after accept into an idle block;
// in_ready low only while the FIFO is full. Define UART_TX_PARITY_EN for an 8E1/8O1 frame (PARITY_ODD selects).
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_buffered_if.slave           s_in,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned BW       = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic P_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx, r_busy;
  logic          w_push, w_pop, w_baud_last;
  logic [7:0]    w_head;

  assign s_in.in_ready = (r_count != CNT_FULL);
  assign w_push        = s_in.in_valid && s_in.in_ready;
  assign w_baud_last   = (r_baud == BAUD_LAST);
  // Pops happen only where a new frame can begin, so the frame in flight is never counted.
  assign w_pop  = (r_count != '0) &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));
  assign w_head = r_mem[r_rd_ptr];

  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_in.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= (^r_shift) ^ P_ODD;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_shift[r_idx + 3'd1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_pop) begin
              // Back-to-back frame: next start bit follows the stop bit with no idle gap.
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_baud  <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
